// File: rtl/pmem_burst_adapter_if.sv
// Bundle of the cache-side line interface and the memory-side burst interface.
// The adapter is the slave; whoever plays cache and memory uses the master view.
interface pmem_burst_adapter_if #(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
);
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic [31:0]       burst_address;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  burst_rdata, burst_resp,
        output pmem_rdata, pmem_resp,
        output burst_address, burst_read, burst_write, burst_wdata
    );

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        output burst_rdata, burst_resp,
        input  pmem_rdata, pmem_resp,
        input  burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/pmem_burst_adapter.sv
// Serves one cache-line request at a time as a BEATS-long burst on a narrow
// memory port, then pulses pmem_resp for one cycle.
module pmem_burst_adapter #(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    pmem_burst_adapter_if.slave   bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic [LINE_W-1:0] rdata_reg, rdata_next;
    logic [31:0]       addr_reg, addr_next;
    logic [BEAT_W-1:0] beat_slice [BEATS];
    logic              last_beat;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign beat_slice[gi] = line_reg[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            line_reg  <= '0;
            rdata_reg <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            line_reg  <= line_next;
            rdata_reg <= rdata_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        line_next  = line_reg;
        rdata_next = rdata_reg;
        addr_next  = addr_reg;
        unique case (state_reg)
            IDLE: begin
                // Write wins over read when both are requested together.
                if (bus.pmem_write || bus.pmem_read) begin
                    state_next = bus.pmem_write ? WRITE : READ;
                    addr_next  = bus.pmem_address & ~32'h1F;
                    line_next  = bus.pmem_wdata;
                    cnt_next   = '0;
                end
            end
            READ: begin
                if (bus.burst_resp) begin
                    line_next[int'(cnt_reg)*BEAT_W +: BEAT_W] = bus.burst_rdata;
                    if (last_beat) begin
                        cnt_next   = '0;
                        rdata_next = line_next;
                        state_next = RESP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.burst_resp) begin
                    if (last_beat) begin
                        cnt_next   = '0;
                        state_next = RESP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request/strobe outputs decode straight from state so reset drops them at once.
    assign bus.pmem_resp     = (state_reg == RESP);
    assign bus.pmem_rdata    = rdata_reg;
    assign bus.burst_address = addr_reg;
    assign bus.burst_read    = (state_reg == READ);
    assign bus.burst_write   = (state_reg == WRITE);
    assign bus.burst_wdata   = (state_reg == WRITE) ? beat_slice[cnt_reg] : '0;
endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Responder end of the cache's physical-memory line interface (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp).
- Accepts one 256-bit line request at a time from the cache.
- Serves the request as a 4-beat burst on a 64-bit memory port.
- Returns the completion pulse to the cache.
- Sits between the cache (or eviction write buffer) and the main memory model/controller.

Parameters:
- BEAT_W, 64: burst data width. LINE_W must be an integer multiple of BEAT_W.
- LINE_W, 256: cache line width.
- BEATS, LINE_W/BEAT_W (=4): beats per line (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pmem_address  input  32  line request address from the cache; bits [4:0] ignored.
- pmem_wdata  input  LINE_W  write line.
- pmem_read  input  1  line read request, held until pmem_resp.
- pmem_write  input  1  line write request, held until pmem_resp.
- pmem_rdata  output  LINE_W  read line, valid when pmem_resp is high.
- pmem_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  line-aligned burst address.
- burst_read  output  1  burst read request, held until last beat.
- burst_write  output  1  burst write request, held until last beat.
- burst_wdata  output  BEAT_W  current write beat.
- burst_rdata  input  BEAT_W  read beat, valid when burst_resp is high.
- burst_resp  input  1  per-beat handshake: one beat transferred per high cycle.

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0; pmem_resp, burst_read, burst_write=0; pmem_rdata, burst_address, burst_wdata=0. A burst in flight is abandoned; memory sees its request drop immediately.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - pmem_write high at the edge -> WRITE.
  - Else pmem_read high -> READ.
  - pmem_write has priority if both are high.
  - On acceptance, latch burst_address={pmem_address[31:5],5'b0}, latch pmem_wdata into the line buffer, clear the beat counter.
- READ:
  - burst_read=1.
  - Each cycle with burst_resp=1, burst_rdata is written into line-buffer slice [cnt*BEAT_W +: BEAT_W]; cnt increments.
  - On the beat with cnt==BEATS-1 -> RESP.
  - burst_resp may be non-consecutive (stall cycles allowed).
- WRITE:
  - burst_write=1; burst_wdata=line buffer slice cnt (beat 0 = bits [63:0]).
  - Each burst_resp consumes the current beat; cnt increments.
  - Last beat -> RESP.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - pmem_rdata=assembled line after a read; after a write it holds its previous value.
  - burst_read/burst_write=0.
  - Always -> IDLE.
- Requester rule: the requester deasserts pmem_read/pmem_write in the cycle after pmem_resp. IDLE samples new requests starting that cycle, so back-to-back requests lose no cycle beyond RESP.
- pmem_rdata holds its value until the next read completion.
- Latency: request accepted at edge t; burst request visible in cycle t+1. With beats on consecutive cycles starting at t+1, pmem_resp is high in cycle t+5. Minimum request-to-resp latency is 5 cycles.
- burst_resp in IDLE or RESP is ignored: no state change, no buffer write.
- Changes to pmem_address or pmem_wdata after acceptance do not affect the transaction in flight.
- burst_address, burst_read and burst_write are stable across all beats of a burst.
- Counter width is clog2(BEATS). The counter wraps to 0 only via the transition to RESP.

Test Plan:
- Read, no stall: pmem_read=1, pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> burst_address=0x0000_1220; pmem_resp high exactly once, 5 cycles after acceptance; pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write with stalls: pmem_write=1, pmem_wdata=256'h0123...CDEF; burst_resp high on cycles 2,5,6,9 after acceptance -> burst_wdata steps through slices [63:0] to [255:192] only on those handshakes; burst_write held for the whole burst; single pmem_resp after the 4th beat.
- Simultaneous pmem_read and pmem_write -> WRITE burst performed, no burst_read; then back-to-back read issued the cycle after resp -> accepted immediately, correct data.
- Stray burst_resp pulses in IDLE, and pmem_address changed mid-burst -> no buffer corruption; burst_address unchanged; returned line matches original address.
- Async rst asserted mid-read after beat 2 -> all outputs 0 immediately, FSM IDLE; next read completes with a full 4-beat burst and correct data.
